bin_to_dec_display: RTL

BIN_TO_DEC_DISPLAY -- requirements
Module: bin_to_dec_display

---
 rtl/bin_to_dec_display.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bin_to_dec_display.sv
// Binary-to-decimal converter feeding an LCD character writer.
// Double-dabble conversion of a 16-bit value into five ASCII digits, emitted one per handshake.
module bin_to_dec_display #(
    parameter bit         LEAD_BLANK = 1'b1,
    parameter logic [3:0] BASE_POS   = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] value_in,
    output logic        busy,
    output logic [7:0]  char_out,
    output logic [3:0]  char_pos,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        done
);

    localparam int unsigned VAL_W  = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned ITER_W = 5;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DIGITS = 5;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [VAL_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  adj;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [7:0]        char_q, char_d;
    logic [3:0]        pos_q, pos_d;
    logic [3:0]        digit;
    logic [3:0]        nib;
    logic              lead_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            char_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            char_q  <= char_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        idx_d     = idx_q;
        adj       = bcd_q;
        digit     = 4'd0;
        nib       = 4'd0;
        lead_zero = 1'b1;

        // Add-3 correction applied before each shift
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = value_in;
                    bcd_d   = '0;
                    iter_d  = '0;
                    idx_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {adj, shift_q} << 1;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(VAL_W - 1)) begin
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (char_ready) begin
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Digit 0 is the ten-thousands place; leading-zero tracking covers digits 0..idx
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_d[4*(DIGITS-1-i) +: 4];
            if (IDX_W'(i) <= idx_d && nib != 4'd0) begin
                lead_zero = 1'b0;
            end
            if (IDX_W'(i) == idx_d) begin
                digit = nib;
            end
        end

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == EMIT);
        done_d  = (state_d == DONE);
        char_d  = 8'h00;
        pos_d   = 4'd0;
        if (state_d == EMIT) begin
            pos_d = BASE_POS + 4'(idx_d);
            if (LEAD_BLANK && lead_zero && idx_d != IDX_W'(DIGITS - 1)) begin
                char_d = 8'h20;
            end else begin
                char_d = 8'h30 + 8'(digit);
            end
        end
    end

    assign busy       = busy_q;
    assign char_valid = valid_q;
    assign done       = done_q;
    assign char_out   = char_q;
    assign char_pos   = pos_q;

endmodule
